// File: rtl/matrix_rx_loader_if.sv
// matrix_rx_loader_if: byte-stream input and matrix-buffer write port of the loader
interface matrix_rx_loader_if #(
    parameter int MAX_N      = 4,
    parameter int ELEM_BYTES = 1
);
    localparam int AW = (MAX_N * MAX_N > 2) ? $clog2(MAX_N * MAX_N) : 1;
    localparam int EW = 8 * ELEM_BYTES;
    logic          clear;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [3:0]    mat_n;
    logic          a_we;
    logic          b_we;
    logic [AW-1:0] wr_addr;
    logic [EW-1:0] wr_data;
    logic          busy;
    logic          load_done;
    logic          size_err;
    logic          timeout_err;
    modport master (
        output clear, rx_data, rx_valid,
        input  mat_n, a_we, b_we, wr_addr, wr_data, busy, load_done, size_err, timeout_err
    );
    modport slave (
        input  clear, rx_data, rx_valid,
        output mat_n, a_we, b_we, wr_addr, wr_data, busy, load_done, size_err, timeout_err
    );
endinterface

// File: rtl/matrix_rx_loader.sv
// matrix_rx_loader: parses a size byte then two square matrices from a UART byte stream into A/B buffer writes
module matrix_rx_loader #(
    parameter int MAX_N       = 4,
    parameter int ELEM_BYTES  = 1,
    parameter int TIMEOUT_CYC = 2_000_000
) (
    input logic clk,
    input logic rst,
    matrix_rx_loader_if.slave bus
);
    localparam int AW = (MAX_N * MAX_N > 2) ? $clog2(MAX_N * MAX_N) : 1;
    localparam int EW = 8 * ELEM_BYTES;
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic [1:0] LAST_B = 2'(ELEM_BYTES - 1);

    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, DONE, ERR} state_t;

    state_t        state_q, state_d;
    logic [3:0]    mat_n_q, mat_n_d;
    logic [3:0]    row_q, row_d;
    logic [3:0]    col_q, col_d;
    logic [1:0]    byte_q, byte_d;
    logic [EW-1:0] asm_q, asm_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          a_we_q, a_we_d;
    logic          b_we_q, b_we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [EW-1:0] data_q, data_d;
    logic          size_err_q, size_err_d;
    logic          tmo_err_q, tmo_err_d;
    logic [EW-1:0] asm_nx;
    logic          col_end;
    logic          mat_end;

    // Next-state logic: size parse, little-endian element assembly, row-major addressing, timeout, clear override
    always_comb begin
        state_d    = state_q;
        mat_n_d    = mat_n_q;
        row_d      = row_q;
        col_d      = col_q;
        byte_d     = byte_q;
        asm_d      = asm_q;
        tmo_d      = tmo_q;
        a_we_d     = 1'b0;
        b_we_d     = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        size_err_d = size_err_q;
        tmo_err_d  = tmo_err_q;
        asm_nx     = asm_q | (EW'(bus.rx_data) << (8 * byte_q));
        col_end    = col_q == mat_n_q - 4'd1;
        mat_end    = col_end && (row_q == mat_n_q - 4'd1);
        case (state_q)
            IDLE: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data != 8'd0 && bus.rx_data <= 8'(MAX_N)) begin
                        mat_n_d = bus.rx_data[3:0];
                        state_d = LOAD_A;
                        tmo_d   = '0;
                        row_d   = '0;
                        col_d   = '0;
                        byte_d  = '0;
                        asm_d   = '0;
                    end else begin
                        size_err_d = 1'b1;
                        state_d    = ERR;
                    end
                end
            end
            LOAD_A, LOAD_B: begin
                if (bus.rx_valid) begin
                    tmo_d = '0;
                    if (byte_q == LAST_B) begin
                        a_we_d = state_q == LOAD_A;
                        b_we_d = state_q == LOAD_B;
                        addr_d = AW'(int'(row_q) * MAX_N + int'(col_q));
                        data_d = asm_nx;
                        asm_d  = '0;
                        byte_d = '0;
                        col_d  = col_end ? 4'd0 : col_q + 4'd1;
                        row_d  = col_end ? row_q + 4'd1 : row_q;
                        if (mat_end) begin
                            row_d   = '0;
                            col_d   = '0;
                            state_d = (state_q == LOAD_A) ? LOAD_B : DONE;
                        end
                    end else begin
                        asm_d  = asm_nx;
                        byte_d = byte_q + 2'd1;
                    end
                end else if (TIMEOUT_CYC != 0 && tmo_q == TMO_LAST) begin
                    tmo_err_d = 1'b1;
                    state_d   = ERR;
                    asm_d     = '0;
                    byte_d    = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: ;
        endcase
        if (bus.clear) begin
            state_d    = IDLE;
            mat_n_d    = '0;
            row_d      = '0;
            col_d      = '0;
            byte_d     = '0;
            asm_d      = '0;
            tmo_d      = '0;
            a_we_d     = 1'b0;
            b_we_d     = 1'b0;
            addr_d     = '0;
            data_d     = '0;
            size_err_d = 1'b0;
            tmo_err_d  = 1'b0;
        end
    end

    // State register with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            mat_n_q    <= '0;
            row_q      <= '0;
            col_q      <= '0;
            byte_q     <= '0;
            asm_q      <= '0;
            tmo_q      <= '0;
            a_we_q     <= 1'b0;
            b_we_q     <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            size_err_q <= 1'b0;
            tmo_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            mat_n_q    <= mat_n_d;
            row_q      <= row_d;
            col_q      <= col_d;
            byte_q     <= byte_d;
            asm_q      <= asm_d;
            tmo_q      <= tmo_d;
            a_we_q     <= a_we_d;
            b_we_q     <= b_we_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            size_err_q <= size_err_d;
            tmo_err_q  <= tmo_err_d;
        end
    end

    assign bus.mat_n       = mat_n_q;
    assign bus.a_we        = a_we_q;
    assign bus.b_we        = b_we_q;
    assign bus.wr_addr     = addr_q;
    assign bus.wr_data     = data_q;
    assign bus.busy        = state_q == LOAD_A || state_q == LOAD_B;
    assign bus.load_done   = state_q == DONE;
    assign bus.size_err    = size_err_q;
    assign bus.timeout_err = tmo_err_q;
endmodule

// File: tb/tb_matrix_rx_loader.sv
// tb_matrix_rx_loader: randomized scoreboard bench for the matrix loader
module tb_matrix_rx_loader;
    localparam int MAX_N = 4;
    localparam int EB    = 2;
    localparam int TMO   = 100;

    typedef struct {
        bit     b;
        int     addr;
        longint data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    wr_t  exp_q[$];
    wr_t  e;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    matrix_rx_loader_if #(.MAX_N(MAX_N), .ELEM_BYTES(EB)) bus ();

    matrix_rx_loader #(.MAX_N(MAX_N), .ELEM_BYTES(EB), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endfunction

    // Monitor: every write strobe must match the oldest expected write
    always @(negedge clk) begin
        if (!rst && (bus.a_we || bus.b_we)) begin
            check("we_exclusive", bus.a_we & bus.b_we, 0);
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", {bus.a_we, bus.b_we}, 0);
            end else begin
                e = exp_q.pop_front();
                check("we_port_b", bus.b_we, e.b);
                check("wr_addr", bus.wr_addr, e.addr);
                check("wr_data", bus.wr_data, e.data);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    function automatic int rgap();
        return ($urandom_range(0, 9) == 0) ? TMO - 1 : int'($urandom_range(0, 2));
    endfunction

    task automatic send_byte(logic [7:0] b, int gap);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        repeat (gap) @(posedge clk);
        if (gap > 0) #1;
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        @(posedge clk);
        #1;
        bus.clear = 1'b0;
    endtask

    task automatic send_elem(bit b, int n, int idx, logic [15:0] v);
        exp_q.push_back('{b, (idx / n) * MAX_N + idx % n, longint'(v)});
        for (int i = 0; i < EB; i++) send_byte(v[8*i +: 8], rgap());
    endtask

    task automatic full_load(int n);
        send_byte(8'(n), rgap());
        for (int m = 0; m < 2; m++)
            for (int k = 0; k < n * n; k++) send_elem(m[0], n, k, 16'($urandom));
        repeat (2) @(posedge clk);
        #1;
        check("load_done", bus.load_done, 1);
        check("busy_after_load", bus.busy, 0);
        check("mat_n", bus.mat_n, n);
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_mat_n"}, bus.mat_n, 0);
        check({tag, "_we"}, {bus.a_we, bus.b_we}, 0);
        check({tag, "_addr_data"}, {bus.wr_addr, bus.wr_data}, 0);
        check({tag, "_flags"}, {bus.busy, bus.load_done, bus.size_err, bus.timeout_err}, 0);
    endtask

    initial begin
        logic [7:0] bad_sizes [3];
        bad_sizes = '{8'h00, 8'h05, 8'hFF};
        bus.clear    = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = '0;
        #2;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        // Two-byte elements, little-endian, 1x1 matrices
        send_byte(8'h01, 0);
        exp_q.push_back('{1'b0, 0, 64'h1234});
        send_byte(8'h34, 0);
        send_byte(8'h12, 0);
        exp_q.push_back('{1'b1, 0, 64'hABCD});
        send_byte(8'hCD, 0);
        send_byte(8'hAB, 0);
        repeat (2) @(posedge clk);
        #1;
        check("le_load_done", bus.load_done, 1);
        check("le_mat_n", bus.mat_n, 1);
        check("le_queue", exp_q.size(), 0);
        do_clear();
        check("le_clear_done", bus.load_done, 0);
        check("le_clear_mat_n", bus.mat_n, 0);
        // Random loads, bytes in DONE ignored
        for (int t = 0; t < 6; t++) begin
            full_load(t == 0 ? MAX_N : t == 1 ? 1 : int'($urandom_range(1, MAX_N)));
            for (int i = 0; i < 3; i++) send_byte(8'($urandom), 0);
            repeat (2) @(posedge clk);
            #1;
            check("done_hold", bus.load_done, 1);
            do_clear();
            check("clear_done", bus.load_done, 0);
            check("clear_mat_n", bus.mat_n, 0);
        end
        // Illegal size bytes
        foreach (bad_sizes[i]) begin
            send_byte(bad_sizes[i], 1);
            check("size_err_set", bus.size_err, 1);
            check("size_err_busy", bus.busy, 0);
            send_byte(8'h01, 0);
            send_byte(8'h02, 0);
            send_byte(8'h03, 2);
            check("size_err_hold", bus.size_err, 1);
            check("size_err_mat_n", bus.mat_n, 0);
            do_clear();
            check("size_err_clear", bus.size_err, 0);
        end
        // Inter-byte timeout with a partial element pending
        send_byte(8'h02, 0);
        send_byte(8'h11, 0);
        repeat (TMO - 1) @(posedge clk);
        #1;
        check("tmo_not_yet", bus.timeout_err, 0);
        check("tmo_still_busy", bus.busy, 1);
        @(posedge clk);
        #1;
        check("tmo_set", bus.timeout_err, 1);
        check("tmo_busy", bus.busy, 0);
        for (int i = 0; i < 4; i++) send_byte(8'($urandom), 0);
        repeat (2) @(posedge clk);
        #1;
        check("tmo_hold", bus.timeout_err, 1);
        do_clear();
        check("tmo_clear", bus.timeout_err, 0);
        // Asynchronous reset during LOAD_B
        send_byte(8'h02, 0);
        for (int k = 0; k < 4; k++) send_elem(1'b0, 2, k, 16'($urandom));
        send_elem(1'b1, 2, 0, 16'($urandom));
        send_byte(8'h5A, 0);
        check("pre_rst_busy", bus.busy, 1);
        #3;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        full_load(2);
        do_clear();
        // Clear coincident with the final B byte
        send_byte(8'h01, 0);
        send_elem(1'b0, 1, 0, 16'h00C3);
        send_byte(8'h77, 0);
        bus.rx_data  = 8'h88;
        bus.rx_valid = 1'b1;
        bus.clear    = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        bus.clear    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("clr_final_done", bus.load_done, 0);
        check("clr_final_idle", {bus.busy, bus.mat_n}, 0);
        check("clr_final_queue", exp_q.size(), 0);
        full_load(1);
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/matrix_rx_loader.md
MATRIX_RX_LOADER -- requirements
Module: matrix_rx_loader

Interface
REQ-001 Parameter MAX_N, default 4, maximum square matrix dimension accepted (2..15).
REQ-002 Parameter ELEM_BYTES, default 1, bytes per matrix element (1..4); element width EW = 8*ELEM_BYTES.
REQ-003 Parameter TIMEOUT_CYC, default 2_000_000, max idle clk cycles between bytes inside a load (0 = timeout disabled).
REQ-004 Derived AW = clog2(MAX_N*MAX_N), minimum 1.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 clear  input  1  synchronous abort/restart; returns block to IDLE.
REQ-008 rx_data  input  8  received UART byte.
REQ-009 rx_valid  input  1  one-cycle strobe, rx_data valid.
REQ-010 mat_n  output  4  accepted matrix dimension.
REQ-011 a_we  output  1  one-cycle write strobe, matrix A buffer.
REQ-012 b_we  output  1  one-cycle write strobe, matrix B buffer.
REQ-013 wr_addr  output  AW  write address, row*MAX_N + col.
REQ-014 wr_data  output  EW  assembled element.
REQ-015 busy  output  1  high in LOAD_A or LOAD_B.
REQ-016 load_done  output  1  level, both matrices loaded.
REQ-017 size_err  output  1  level, illegal size byte received.
REQ-018 timeout_err  output  1  level, inter-byte timeout expired.

Function
REQ-019 FSM states: IDLE, LOAD_A, LOAD_B, DONE, ERR.
REQ-020 IDLE: first rx_valid byte is size; 1..MAX_N -> latch mat_n, go LOAD_A; else (0 or >MAX_N) -> size_err=1, go ERR.
REQ-021 LOAD_A/LOAD_B: bytes assembled little-endian, first byte into bits [7:0]; element complete after ELEM_BYTES bytes.
REQ-022 On element completion, a_we (LOAD_A) or b_we (LOAD_B) SHALL pulse exactly one cycle, in the cycle after the final byte's rx_valid, with wr_addr/wr_data valid that cycle.
REQ-023 Element order row-major: col increments 0..mat_n-1, then wraps to 0 and row increments; wr_addr = row*MAX_N + col (stride MAX_N, independent of mat_n).
REQ-024 After element (mat_n-1, mat_n-1) of A: row, col, byte count clear, go LOAD_B; of B: go DONE.
REQ-025 DONE: load_done=1, mat_n held, rx_valid ignored until clear or rst.
REQ-026 ERR: rx_valid ignored, error flags held until clear or rst.
REQ-027 Timeout counter clears on every rx_valid and on entry to LOAD_A; in LOAD_A/LOAD_B reaching TIMEOUT_CYC without rx_valid -> timeout_err=1, go ERR, partial element discarded; IDLE and DONE never time out.
REQ-028 clear in any state -> IDLE next cycle; flags, counters, assembly register, mat_n cleared; clear beats a simultaneous rx_valid (byte dropped, no write strobe).
REQ-029 a_we and b_we SHALL never be high in the same cycle; no strobe in IDLE, DONE, ERR.
REQ-030 rx_valid on consecutive cycles SHALL be accepted with no byte loss.

Reset
REQ-031 rst high -> state IDLE, all outputs 0, all counters and assembly register 0, immediately, independent of clk.
REQ-032 rst asserted mid-load discards all progress; after release the next byte is a size byte.

Verification
REQ-033 MAX_N=4, ELEM_BYTES=1: size 0x03, A bytes 01 02 03 04 03 04 04 03 04 -> nine a_we pulses at addr 0,1,2,4,5,6,8,9,10 with those data; B bytes 05 06 07 08 07 08 08 07 08 -> nine b_we pulses, same addresses; load_done=1 after the last.
REQ-034 Size 0x00, then size 0x05 after clear (MAX_N=4) -> size_err=1 each time, no write strobes; clear -> size_err=0, IDLE.
REQ-035 ELEM_BYTES=2, size 0x01, bytes 34 12 then CD AB -> a_we data 0x1234 addr 0, b_we data 0xABCD addr 0, load_done=1.
REQ-036 TIMEOUT_CYC=100, size 0x02, one A byte, then idle 100 cycles -> timeout_err=1, state ERR, no further strobes on later bytes.
REQ-037 Async rst pulse between clk edges during LOAD_B -> outputs 0 at once; new size 0x02 plus 8 bytes -> normal load, load_done=1.
REQ-038 clear coincident with final B byte -> no b_we, load_done stays 0, block in IDLE.
